// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops register their result on the accepting edge; SLL walks
// an accumulator left one bit per cycle and presents b << shamt when done.
//
// Handshake: a request is taken on any rising edge where i_valid && o_ready;
// a result is handed off on any rising edge where o_valid && i_ready. Both
// can happen on the same edge, giving back-to-back one-cycle throughput.
module alu_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [3:0]         i_ALUCtrl,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_zero,
  output logic               o_overflow,
  output logic               o_illegal,
  output logic [1:0]         o_state
);

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1100;
  localparam logic [3:0] OP_OR  = 4'b1101;
  localparam logic [3:0] OP_XOR = 4'b1111;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;

  logic               accept;
  logic               start_shift;
  logic               shift_done;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_ill;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   acc_next;

  // The result register holds exactly while state is OUT.
  assign o_valid     = (state == OUT);
  assign o_ready     = (state != SHIFT) && (!o_valid || i_ready);
  assign o_state     = state;
  assign accept      = i_valid && o_ready;
  assign start_shift = (i_ALUCtrl == OP_SLL) && (i_shamt != '0);
  assign shift_done  = (state == SHIFT) && (cnt == SHAMT_W'(1));
  assign sum         = i_a + i_b;
  assign diff        = i_a - i_b;
  assign acc_next    = acc << 1;

  // Single-cycle result, overflow and illegal-code decode for the current request.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (i_ALUCtrl)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND: alu_res = i_a & i_b;
      OP_OR:  alu_res = i_a | i_b;
      OP_XOR: alu_res = i_a ^ i_b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLL: alu_res = i_b;  // only reached directly when shamt is zero
      default: alu_ill = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: accept wins, then shift completion, then output hand-off.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = start_shift ? SHIFT : OUT;
    end else begin
      case (state)
        SHIFT:   if (cnt == SHAMT_W'(1)) state_next = OUT;
        OUT:     if (i_ready) state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  // Datapath: load result or shifter on accept, step the shifter, hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      o_result   <= '0;
      o_zero     <= 1'b0;
      o_overflow <= 1'b0;
      o_illegal  <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        acc <= i_b;
        cnt <= i_shamt;
      end else begin
        o_result   <= alu_res;
        o_zero     <= (alu_res == '0);
        o_overflow <= alu_ovf;
        o_illegal  <= alu_ill;
      end
    end else if (state == SHIFT) begin
      acc <= acc_next;
      cnt <= cnt - SHAMT_W'(1);
      if (shift_done) begin
        o_result   <= acc_next;
        o_zero     <= (acc_next == '0);
        o_overflow <= 1'b0;
        o_illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed cases with literal expectations, then
// randomized traffic with random downstream backpressure, all checked
// every cycle against a latency/result model built from plain arithmetic.
module tb_alu_exec;

  localparam int W  = 32;
  localparam int SW = 5;

  // ---------------- clock / reset ----------------
  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_valid = 1'b0;
  logic [3:0]    i_ALUCtrl = 4'b0;
  logic [W-1:0]  i_a = '0;
  logic [W-1:0]  i_b = '0;
  logic [SW-1:0] i_shamt = '0;
  logic          i_ready;
  logic          o_ready, o_valid, o_zero, o_overflow, o_illegal;
  logic [W-1:0]  o_result;
  logic [1:0]    o_state;

  logic force_rdy = 1'b1;
  logic rand_rdy  = 1'b0;
  logic rnd_rdy   = 1'b1;
  logic chk_en    = 1'b0;
  assign i_ready = rand_rdy ? rnd_rdy : force_rdy;

  int checks   = 0;
  int failures = 0;

  alu_exec #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_ALUCtrl(i_ALUCtrl), .i_a(i_a), .i_b(i_b), .i_shamt(i_shamt),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_zero(o_zero), .o_overflow(o_overflow), .o_illegal(o_illegal),
    .o_state(o_state)
  );

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic         ill;
    logic         ovf;
    logic [W-1:0] res;
  } calc_t;

  function automatic calc_t calc(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [SW-1:0] sh);
    calc_t c;
    c = '0;
    case (op)
      4'b1000: begin c.res = a + b; c.ovf = (a[W-1] == b[W-1]) && (c.res[W-1] != a[W-1]); end
      4'b1001: begin c.res = a - b; c.ovf = (a[W-1] != b[W-1]) && (c.res[W-1] != a[W-1]); end
      4'b1100: c.res = a & b;
      4'b1101: c.res = a | b;
      4'b1111: c.res = a ^ b;
      4'b0101: c.res = ($signed(a) < $signed(b)) ? W'(1) : '0;
      4'b0000: c.res = b << sh;
      default: c.ill = 1'b1;
    endcase
    return c;
  endfunction

  calc_t        cur;
  calc_t        m_pend;
  logic         m_valid, m_zero, m_ovf, m_ill, m_ready;
  logic [W-1:0] m_res;
  int           m_busy;

  assign cur     = calc(i_ALUCtrl, i_a, i_b, i_shamt);
  assign m_ready = (m_busy == 0) && (!m_valid || i_ready);

  // Model: a shift of k>0 occupies the block for k edges, then its result appears.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_valid <= 1'b0; m_res <= '0; m_zero <= 1'b0; m_ovf <= 1'b0; m_ill <= 1'b0;
      m_busy <= 0; m_pend <= '0;
    end else if (i_valid && m_ready) begin
      if (i_ALUCtrl == 4'b0000 && i_shamt != '0) begin
        m_busy <= int'(i_shamt); m_pend <= cur; m_valid <= 1'b0;
      end else begin
        m_res <= cur.res; m_zero <= (cur.res == '0); m_ovf <= cur.ovf;
        m_ill <= cur.ill; m_valid <= 1'b1;
      end
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_res <= m_pend.res; m_zero <= (m_pend.res == '0); m_ovf <= m_pend.ovf;
        m_ill <= m_pend.ill; m_valid <= 1'b1;
      end
    end else if (m_valid && i_ready) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always begin
    @(negedge i_clk);
    #2;
    if (chk_en) begin
      cmp("ready",    W'(o_ready),    W'(m_ready));
      cmp("valid",    W'(o_valid),    W'(m_valid));
      cmp("result",   o_result,       m_res);
      cmp("zero",     W'(o_zero),     W'(m_zero));
      cmp("overflow", W'(o_overflow), W'(m_ovf));
      cmp("illegal",  W'(o_illegal),  W'(m_ill));
    end
  end

  // Random downstream readiness.
  always @(negedge i_clk) rnd_rdy = ($urandom_range(0, 3) != 0);

  // ---------------- driver tasks ----------------
  time last_accept;

  task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [SW-1:0] sh);
    int n;
    @(negedge i_clk);
    i_valid = 1'b1; i_ALUCtrl = op; i_a = a; i_b = b; i_shamt = sh;
    n = 0;
    #1;
    while (!o_ready && n < 100) begin
      @(negedge i_clk); #1; n++;
    end
    if (n >= 100) begin
      failures++;
      $display("FAIL send_timeout actual=o_ready_low required=accept_within_100");
    end
    @(posedge i_clk);
    last_accept = $time;
    #1;
    i_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (which counts as 1) to o_valid rising.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!o_valid && edges < 40) begin
      @(posedge i_clk); #1; edges++;
    end
    if (!o_valid) begin
      failures++;
      $display("FAIL valid_timeout actual=0 required=1");
    end
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]   ops [7] = '{4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1111, 4'b0101, 4'b0000};
  logic [W-1:0] edge_vals [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1};

  initial begin
    int   e;
    int   vcnt;
    time  t0;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [SW-1:0] sh;

    // Reset state.
    @(negedge i_clk);
    chk_en = 1'b1;
    @(negedge i_clk); #1;
    cmp("rst_ready",  W'(o_ready), 1);
    cmp("rst_valid",  W'(o_valid), 0);
    cmp("rst_result", o_result, 0);
    cmp("rst_flags",  W'({o_zero, o_overflow, o_illegal}), 0);
    i_rst_n = 1'b1;

    // 1: add overflow.
    send(4'b1000, 32'h7FFF_FFFF, 32'h1, 5'd0);
    wait_valid(e);
    cmp("add_lat", e, 1);
    cmp("add_res", o_result, 32'h8000_0000);
    cmp("add_ovf", W'(o_overflow), 1);
    cmp("add_zero", W'(o_zero), 0);

    // 2: sub to zero, slt signed.
    send(4'b1001, 32'd5, 32'd5, 5'd0);
    cmp("sub_res", o_result, 0);
    cmp("sub_flags", W'({o_zero, o_overflow}), W'(2'b10));
    send(4'b0101, 32'hFFFF_FFFF, 32'h1, 5'd0);
    cmp("slt_res", o_result, 1);

    // 3: iterative shift and shamt=0.
    send(4'b0000, 32'h0, 32'h3, 5'd4);
    cmp("sll_busy", W'(o_ready), 0);
    wait_valid(e);
    cmp("sll_lat", e, 5);
    cmp("sll_res", o_result, 32'h30);
    send(4'b0000, 32'h0, 32'hABCD_0123, 5'd0);
    wait_valid(e);
    cmp("sll0_lat", e, 1);
    cmp("sll0_res", o_result, 32'hABCD_0123);

    // 4: back-to-back logic ops.
    send(4'b1100, 32'hF0F0, 32'hFF00, 5'd0);
    t0 = last_accept;
    cmp("and_res", o_result, 32'hF000);
    send(4'b1101, 32'hF0F0, 32'hFF00, 5'd0);
    cmp("or_res", o_result, 32'hFFF0);
    cmp("b2b_gap1", W'(last_accept - t0), 10);
    t0 = last_accept;
    send(4'b1111, 32'hF0F0, 32'hFF00, 5'd0);
    cmp("xor_res", o_result, 32'h0FF0);
    cmp("b2b_gap2", W'(last_accept - t0), 10);

    // 5: backpressure.
    repeat (2) @(negedge i_clk);
    force_rdy = 1'b0;
    send(4'b1000, 32'd3, 32'd4, 5'd0);
    @(negedge i_clk);
    i_valid = 1'b1; i_ALUCtrl = 4'b1001; i_a = 32'd10; i_b = 32'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp("bp_ready", W'(o_ready), 0);
      cmp("bp_hold",  o_result, 32'd7);
      cmp("bp_valid", W'(o_valid), 1);
      @(negedge i_clk);
    end
    force_rdy = 1'b1;
    #1;
    cmp("bp_release", W'(o_ready), 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    cmp("bp_next", o_result, 32'd9);

    // 6: reset mid-shift, then an illegal code.
    repeat (2) @(negedge i_clk);
    send(4'b0000, 32'h0, 32'h1, 5'd20);
    repeat (7) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    cmp("mid_rst_valid",  W'(o_valid), 0);
    cmp("mid_rst_result", o_result, 0);
    cmp("mid_rst_ready",  W'(o_ready), 1);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge i_clk); #1;
      if (o_valid) vcnt++;
    end
    cmp("no_valid_after_rst", vcnt, 0);
    send(4'b0011, 32'd5, 32'd6, 5'd0);
    cmp("ill_flag", W'(o_illegal), 1);
    cmp("ill_res",  o_result, 0);

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 6)];
      case ($urandom_range(0, 3))
        0: begin a = edge_vals[$urandom_range(0, 4)]; b = edge_vals[$urandom_range(0, 4)]; end
        1: begin a = $urandom; b = a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      sh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      send(op, a, b, sh);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge i_clk);
    end
    rand_rdy  = 1'b0;
    force_rdy = 1'b1;
    repeat (40) @(negedge i_clk);

    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
